vga_timing_rx: RTL and testbench
================================

VGA_TIMING_RX -- requirements
Module: vga_timing_rx

Interface
REQ-001 SHALL have parameters, one per line:
- H_TOTAL, 800, pixel clocks per line
- V_TOTAL, 525, lines per frame
- H_ACT_START, 143, first active h position
- H_ACT_END, 783, first inactive h position after the active region
- V_ACT_START, 35, first active line
- V_ACT_END, 515, first inactive line after the active region
REQ-002 SHALL have ports, one per line, clock and reset first:
- vga_clk  in  1  pixel clock
- clr  in  1  reset; one clock, reset asynchronous and active-high
- hs  in  1  active-low horizontal sync
- vs  in  1  active-low vertical sync
- r, g, b  in  4 each  pixel colour
- locked  out  1  timing lock held
- px_valid  out  1  active-region pixel present
- row_addr  out  9  row of the current pixel
- col_addr  out  10  column of the current pixel
- px_rgb  out  12  {r,g,b} of the current pixel
- frame_start  out  1  one-cycle pulse at frame position (0,0)
- err_h  out  1  one-cycle pulse on line-timing violation
- err_v  out  1  one-cycle pulse on frame-timing violation
- frame_px_cnt  out  19  count of non-zero pixels in the last complete frame
- cnt_valid  out  1  one-cycle pulse when frame_px_cnt updates

Function
REQ-003 SHALL register hs, vs, r, g and b once (stage S1); all decoding SHALL use only S1 values.
REQ-004 SHALL define an hs fall as S1 hs going from 1 to 0; that cycle is h position 0. The vs fall is defined the same way.
REQ-005 SHALL keep h_cnt (10 bit) and v_cnt (10 bit) counters. h_cnt SHALL wrap H_TOTAL-1 -> 0. v_cnt SHALL increment on the h wrap and wrap V_TOTAL-1 -> 0.
REQ-006 SHALL implement the FSM states SEARCH, H_ACQ, V_ACQ and LOCKED.
REQ-007 SEARCH: on an hs fall, SHALL set h_cnt to 0 and go to H_ACQ.
REQ-008 H_ACQ: on two consecutive hs periods of exactly H_TOTAL cycles, SHALL go to V_ACQ; any other period length SHALL restart the count, and no err pulse is raised.
REQ-009 V_ACQ: on a vs fall coincident with an hs fall, SHALL set v_cnt to 0 and go to LOCKED. The hs-period check continues in this state; a bad hs period SHALL return the FSM to H_ACQ.
REQ-010 LOCKED: SHALL pulse err_h and go to SEARCH, deasserting locked, if:
- an hs fall occurs with h_cnt != H_TOTAL-1, or
- h_cnt == H_TOTAL-1 passes with no hs fall.
REQ-011 LOCKED: SHALL pulse err_v and go to SEARCH if:
- a vs fall occurs other than at a line wrap with v_cnt == V_TOTAL-1, or
- that wrap occurs with no vs fall.
- If the err_h and err_v conditions occur in the same cycle, both SHALL pulse.
REQ-012 locked SHALL be 1 exactly while in LOCKED.
REQ-013 In LOCKED with H_ACT_START <= h_cnt < H_ACT_END and V_ACT_START <= v_cnt < V_ACT_END, outputs SHALL present:
- px_valid = 1
- col_addr = h_cnt - H_ACT_START
- row_addr = v_cnt - V_ACT_START
- px_rgb = S1 colour
Otherwise px_valid = 0 and the other three outputs hold their last values.
REQ-014 All outputs SHALL be registered; a pixel sampled at the ports in cycle N appears at the outputs in cycle N+2.
REQ-015 frame_start SHALL pulse with px_valid for row 0, col 0.
REQ-016 The non-zero pixel counter SHALL:
- clear at frame_start,
- accumulate px_valid pixels with px_rgb != 0,
- on the last active pixel (row 479, col 639), load frame_px_cnt including that pixel and pulse cnt_valid.
REQ-017 Loss of lock mid-frame SHALL discard the partial count; frame_px_cnt SHALL keep its previous value and cnt_valid SHALL NOT pulse.

Reset
REQ-018 While clr = 1, all outputs, counters and the S1 register SHALL be 0, and the FSM SHALL be in SEARCH.
REQ-019 Reset mid-frame SHALL require a full reacquisition (REQ-007..009) before locked rises again.

Structure
REQ-020 The timing constants and the FSM state encoding SHALL live in the shared package vga_pkg, also used by Vga.
REQ-021 The falling-edge detection for hs and vs SHALL be one sub-module, sync_fall_det, instantiated twice.

Verification
REQ-022 Vga drives the bench with the px inputs at 0:
- locked rises at the first vs fall after two good lines,
- frame_start pulses every 420000 cycles,
- frame_px_cnt = 0 and cnt_valid pulses once per frame.
REQ-023 Pixel (0,0) = 0xFFF, all other pixels 0 -> one px_valid cycle shows row_addr 0, col_addr 0, px_rgb 0xFFF; frame_px_cnt = 1.
REQ-024 An all-0x00F frame -> frame_px_cnt = 307200.
REQ-025 A single line of 799 cycles while LOCKED:
- err_h pulses once and locked falls,
- relock occurs at the next frame boundary,
- no err_v pulse.
REQ-026 vs falls one line early -> err_v pulses once, locked falls, and frame_px_cnt keeps its previous value.
REQ-027 clr is pulsed 3 cycles at row 200:
- all outputs are 0 during reset,
- locked stays 0 until the next full acquisition.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and receiver FSM state encoding.
package vga_pkg;

  localparam int VGA_H_TOTAL     = 800;
  localparam int VGA_V_TOTAL     = 525;
  localparam int VGA_H_ACT_START = 143;
  localparam int VGA_H_ACT_END   = 783;
  localparam int VGA_V_ACT_START = 35;
  localparam int VGA_V_ACT_END   = 515;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    H_ACQ  = 2'd1,
    V_ACQ  = 2'd2,
    LOCKED = 2'd3
  } state_t;

endpackage

// File: rtl/sync_fall_det.sv
// 1->0 edge detector on an already-registered sync signal.
module sync_fall_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_fall
);

  logic r_prev;

  // remember the previous sample so a falling step is visible this cycle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_prev <= 1'b0;
    else       r_prev <= i_sig;
  end

  assign o_fall = r_prev & ~i_sig;

endmodule

// File: rtl/vga_timing_rx.sv
// VGA timing receiver: locks onto hs/vs, decodes active pixels, counts
// non-zero pixels per complete frame.
module vga_timing_rx
  import vga_pkg::*;
#(
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int H_ACT_START = VGA_H_ACT_START,
  parameter int H_ACT_END   = VGA_H_ACT_END,
  parameter int V_ACT_START = VGA_V_ACT_START,
  parameter int V_ACT_END   = VGA_V_ACT_END
) (
  input  logic        vga_clk,
  input  logic        clr,
  input  logic        hs,
  input  logic        vs,
  input  logic [3:0]  r,
  input  logic [3:0]  g,
  input  logic [3:0]  b,
  output logic        locked,
  output logic        px_valid,
  output logic [8:0]  row_addr,
  output logic [9:0]  col_addr,
  output logic [11:0] px_rgb,
  output logic        frame_start,
  output logic        err_h,
  output logic        err_v,
  output logic [18:0] frame_px_cnt,
  output logic        cnt_valid
);

  localparam logic [9:0] HL  = 10'(H_TOTAL - 1);
  localparam logic [9:0] VL  = 10'(V_TOTAL - 1);
  localparam logic [9:0] HAS = 10'(H_ACT_START);
  localparam logic [9:0] HAE = 10'(H_ACT_END);
  localparam logic [9:0] VAS = 10'(V_ACT_START);
  localparam logic [9:0] VAE = 10'(V_ACT_END);
  localparam logic [9:0] HLA = 10'(H_ACT_END - 1);
  localparam logic [9:0] VLA = 10'(V_ACT_END - 1);

  logic        r_hs, r_vs;
  logic [11:0] r_rgb;
  logic        w_hs_fall, w_vs_fall;
  logic [9:0]  r_h_cnt, r_v_cnt, w_h_nxt, w_v_nxt;
  state_t      r_state;
  logic        r_h_ok;
  logic [18:0] r_acc, w_base, w_sum;
  logic        w_h_wrap, w_h_good, w_h_bad, w_f_wrap, w_lk;
  logic        w_err_h, w_err_v, w_act, w_first, w_last, w_nz;

  // S1: single input register stage; everything downstream sees only these
  always_ff @(posedge vga_clk or posedge clr) begin
    if (clr) begin
      r_hs  <= 1'b0;
      r_vs  <= 1'b0;
      r_rgb <= '0;
    end else begin
      r_hs  <= hs;
      r_vs  <= vs;
      r_rgb <= {r, g, b};
    end
  end

  sync_fall_det u_hs_fall (.i_clk(vga_clk), .i_rst(clr), .i_sig(r_hs), .o_fall(w_hs_fall));
  sync_fall_det u_vs_fall (.i_clk(vga_clk), .i_rst(clr), .i_sig(r_vs), .o_fall(w_vs_fall));

  // h_cnt reaches H_TOTAL-1 in the cycle a correct hs fall shows up, so the
  // next-count value is the position of the S1 sample being decoded now
  assign w_h_wrap = (r_h_cnt == HL);
  assign w_h_good = w_hs_fall & w_h_wrap;
  assign w_h_bad  = w_hs_fall ^ w_h_wrap;
  assign w_f_wrap = w_h_wrap & (r_v_cnt == VL);
  assign w_lk     = (r_state == LOCKED);
  assign w_err_h  = w_lk & w_h_bad;
  assign w_err_v  = w_lk & (w_vs_fall ^ w_f_wrap);

  // next h/v position; a vs+hs fall during V_ACQ pins the frame origin
  always_comb begin
    w_h_nxt = r_h_cnt + 10'd1;
    if (w_hs_fall || w_h_wrap) w_h_nxt = '0;
    w_v_nxt = r_v_cnt;
    if (r_state == V_ACQ && w_h_good && w_vs_fall) w_v_nxt = '0;
    else if (w_h_wrap) w_v_nxt = (r_v_cnt == VL) ? '0 : r_v_cnt + 10'd1;
  end

  assign w_act   = w_lk & ~w_err_h & ~w_err_v &
                   (w_h_nxt >= HAS) & (w_h_nxt < HAE) &
                   (w_v_nxt >= VAS) & (w_v_nxt < VAE);
  assign w_first = w_act & (w_h_nxt == HAS) & (w_v_nxt == VAS);
  assign w_last  = w_act & (w_h_nxt == HLA) & (w_v_nxt == VLA);
  assign w_nz    = |r_rgb;
  assign w_base  = w_first ? '0 : r_acc;
  assign w_sum   = w_base + {18'd0, w_nz};

  // position counters
  always_ff @(posedge vga_clk or posedge clr) begin
    if (clr) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else begin
      r_h_cnt <= w_h_nxt;
      r_v_cnt <= w_v_nxt;
    end
  end

  // acquisition FSM; locked mirrors LOCKED as a registered output
  always_ff @(posedge vga_clk or posedge clr) begin
    if (clr) begin
      r_state <= SEARCH;
      r_h_ok  <= 1'b0;
      locked  <= 1'b0;
    end else begin
      case (r_state)
        SEARCH: if (w_hs_fall) begin
          r_h_ok  <= 1'b0;
          r_state <= H_ACQ;
        end
        H_ACQ: if (w_h_good) begin
          r_h_ok <= ~r_h_ok;
          if (r_h_ok) r_state <= V_ACQ;
        end else if (w_h_bad) begin
          r_h_ok <= 1'b0;
        end
        V_ACQ: if (w_h_bad) begin
          r_h_ok  <= 1'b0;
          r_state <= H_ACQ;
        end else if (w_h_good && w_vs_fall) begin
          r_state <= LOCKED;
          locked  <= 1'b1;
        end
        LOCKED: if (w_err_h || w_err_v) begin
          r_state <= SEARCH;
          locked  <= 1'b0;
        end
        default: r_state <= SEARCH;
      endcase
    end
  end

  // pixel outputs, error pulses and the per-frame non-zero pixel count
  always_ff @(posedge vga_clk or posedge clr) begin
    if (clr) begin
      px_valid     <= 1'b0;
      row_addr     <= '0;
      col_addr     <= '0;
      px_rgb       <= '0;
      frame_start  <= 1'b0;
      err_h        <= 1'b0;
      err_v        <= 1'b0;
      frame_px_cnt <= '0;
      cnt_valid    <= 1'b0;
      r_acc        <= '0;
    end else begin
      px_valid    <= w_act;
      frame_start <= w_first;
      err_h       <= w_err_h;
      err_v       <= w_err_v;
      cnt_valid   <= w_last;
      if (w_act) begin
        col_addr <= w_h_nxt - HAS;
        row_addr <= 9'(w_v_nxt - VAS);
        px_rgb   <= r_rgb;
      end
      // a partial frame never reaches the last pixel, so it is simply dropped
      if (!w_lk)      r_acc <= '0;
      else if (w_act) r_acc <= w_sum;
      if (w_last) frame_px_cnt <= w_sum;
    end
  end

endmodule

// File: tb/tb_vga_timing_rx.sv
// Bench for vga_timing_rx on a reduced raster; pixel and count scoreboards.
module tb_vga_timing_rx;

  localparam int HT = 20, VT = 12, HAS = 5, HAE = 15, VAS = 2, VAE = 8;
  localparam int HS_W = 3, VS_L = 2;
  localparam int FRAME = HT * VT;
  localparam int NONE = 99;

  logic        vga_clk = 1'b0;
  logic        clr = 1'b1, hs = 1'b1, vs = 1'b1;
  logic [3:0]  r = '0, g = '0, b = '0;
  logic        locked, px_valid, frame_start, err_h, err_v, cnt_valid;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic [11:0] px_rgb;
  logic [18:0] frame_px_cnt;

  vga_timing_rx #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACT_START(HAS), .H_ACT_END(HAE),
    .V_ACT_START(VAS), .V_ACT_END(VAE)
  ) dut (
    .vga_clk(vga_clk), .clr(clr), .hs(hs), .vs(vs), .r(r), .g(g), .b(b),
    .locked(locked), .px_valid(px_valid), .row_addr(row_addr),
    .col_addr(col_addr), .px_rgb(px_rgb), .frame_start(frame_start),
    .err_h(err_h), .err_v(err_v), .frame_px_cnt(frame_px_cnt),
    .cnt_valid(cnt_valid)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct packed {
    logic [8:0]  row;
    logic [9:0]  col;
    logic [11:0] rgb;
    logic        fs;
  } px_t;
  typedef struct { px_t px; int cyc; } px_exp_t;
  typedef struct { logic [18:0] cnt; int cyc; } cnt_exp_t;

  px_exp_t  px_q[$];
  cnt_exp_t cnt_q[$];

  int n_chk = 0, n_fail = 0, cyc = 0, n_errh = 0, n_errv = 0;
  int lk_rise = -1, last_fs = -1, t0 = 0, eh0 = 0, ev0 = 0;
  bit fs_gap = 1'b0;
  logic lk_prev = 1'b0;
  logic [18:0] exp_fpc = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: inputs were set before the edge, outputs sampled on negedge
  task automatic step();
    px_exp_t  pe;
    cnt_exp_t ce;
    @(posedge vga_clk);
    @(negedge vga_clk);
    cyc++;
    if (clr)
      chk("rst_outs", {locked, px_valid, row_addr, col_addr, px_rgb, frame_start,
                       err_h, err_v, frame_px_cnt, cnt_valid}, 64'd0);
    if (px_valid) begin
      if (px_q.size() == 0) chk("px_unexpected", px_valid, 0);
      else begin
        pe = px_q.pop_front();
        chk("px_cycle", cyc, pe.cyc);
        chk("px_data", {row_addr, col_addr, px_rgb, frame_start}, pe.px);
      end
    end else if (px_q.size() != 0 && px_q[0].cyc <= cyc) begin
      pe = px_q.pop_front();
      chk("px_missing", px_valid, 1);
    end
    if (cnt_valid) begin
      if (cnt_q.size() == 0) chk("cnt_unexpected", cnt_valid, 0);
      else begin
        ce = cnt_q.pop_front();
        chk("cnt_cycle", cyc, ce.cyc);
        chk("cnt_value", frame_px_cnt, ce.cnt);
      end
    end else if (cnt_q.size() != 0 && cnt_q[0].cyc <= cyc) begin
      ce = cnt_q.pop_front();
      chk("cnt_missing", cnt_valid, 1);
    end
    if (frame_start) begin
      chk("fs_with_px", px_valid, 1);
      if (fs_gap && last_fs >= 0) chk("fs_period", cyc - last_fs, FRAME);
      last_fs = cyc;
    end
    n_errh += int'(err_h);
    n_errv += int'(err_v);
    if (locked && !lk_prev) lk_rise = cyc;
    lk_prev = locked;
  endtask

  function automatic logic [11:0] pix(input int mode, input int h, input int v);
    logic [11:0] c;
    case (mode)
      0:       c = 12'h000;
      1:       c = (h == HAS && v == VAS) ? 12'hFFF : 12'h000;
      2:       c = 12'h00F;
      default: c = ($urandom_range(3) == 0) ? 12'h000 : 12'($urandom);
    endcase
    return c;
  endfunction

  // drive one frame; lk says whether the receiver should be locked from its
  // first line, short_ln gets one cycle less, rst_ln gets a 3-cycle clr
  task automatic run_frame(input int mode, input bit lk, input int short_ln,
                           input int nlines, input int rst_ln);
    int sum, len, last_ok;
    logic [11:0] c;
    px_exp_t  pe;
    cnt_exp_t ce;
    sum = 0;
    last_ok = (short_ln < rst_ln - 1) ? short_ln : rst_ln - 1;
    for (int v = 0; v < nlines; v++) begin
      len = (v == short_ln) ? HT - 1 : HT;
      for (int h = 0; h < len; h++) begin
        c = pix(mode, h, v);
        clr = (v == rst_ln && h < 3);
        if (clr) exp_fpc = '0;
        if (lk && v <= last_ok && h >= HAS && h < HAE && v >= VAS && v < VAE) begin
          pe.px.row = 9'(v - VAS);
          pe.px.col = 10'(h - HAS);
          pe.px.rgb = c;
          pe.px.fs  = (h == HAS && v == VAS);
          pe.cyc    = cyc + 2;
          px_q.push_back(pe);
          if (c != 12'h000) sum++;
          if (h == HAE - 1 && v == VAE - 1) begin
            ce.cnt = 19'(sum);
            ce.cyc = cyc + 2;
            cnt_q.push_back(ce);
            exp_fpc = 19'(sum);
          end
        end
        hs = ~(h < HS_W);
        vs = ~(v < VS_L);
        {r, g, b} = c;
        step();
      end
    end
    clr = 1'b0;
  endtask

  initial begin
    // reset with idle syncs
    repeat (3) step();
    clr = 1'b0;
    repeat (4) step();
    chk("idle_locked", locked, 0);

    // acquisition frame, then all-zero locked frames
    run_frame(0, 0, NONE, VT, NONE);
    chk("acq_locked", locked, 0);
    lk_rise = -1; t0 = cyc; fs_gap = 1'b1; last_fs = -1;
    run_frame(0, 1, NONE, VT, NONE);
    chk("lock_rise", lk_rise, t0 + 2);
    chk("zero_locked", locked, 1);
    run_frame(0, 1, NONE, VT, NONE);
    run_frame(0, 1, NONE, VT, NONE);
    fs_gap = 1'b0;
    chk("zero_fpc", frame_px_cnt, exp_fpc);
    chk("zero_errh", n_errh, 0);
    chk("zero_errv", n_errv, 0);

    // single white origin pixel, full 0x00F frame, random frame
    run_frame(1, 1, NONE, VT, NONE);
    chk("one_fpc", frame_px_cnt, exp_fpc);
    run_frame(2, 1, NONE, VT, NONE);
    chk("full_fpc", frame_px_cnt, 19'((HAE - HAS) * (VAE - VAS)));
    run_frame(3, 1, NONE, VT, NONE);
    chk("rand_fpc", frame_px_cnt, exp_fpc);

    // one short line mid-frame
    eh0 = n_errh; ev0 = n_errv;
    run_frame(3, 1, 3, VT, NONE);
    chk("short_errh", n_errh - eh0, 1);
    chk("short_errv", n_errv - ev0, 0);
    chk("short_locked", locked, 0);
    chk("short_fpc_kept", frame_px_cnt, exp_fpc);
    lk_rise = -1; t0 = cyc;
    run_frame(2, 1, NONE, VT, NONE);
    chk("short_relock", lk_rise, t0 + 2);
    chk("short_after_fpc", frame_px_cnt, exp_fpc);

    // vs falls one line early
    run_frame(3, 1, NONE, VT - 1, NONE);
    chk("early_fpc", frame_px_cnt, exp_fpc);
    eh0 = n_errh; ev0 = n_errv;
    run_frame(1, 0, NONE, VT, NONE);
    chk("early_errv", n_errv - ev0, 1);
    chk("early_errh", n_errh - eh0, 0);
    chk("early_locked", locked, 0);
    chk("early_fpc_kept", frame_px_cnt, exp_fpc);
    lk_rise = -1; t0 = cyc;
    run_frame(2, 1, NONE, VT, NONE);
    chk("early_relock", lk_rise, t0 + 2);

    // clr pulse in the middle of the active region
    lk_rise = -1;
    run_frame(2, 1, NONE, VT, 5);
    chk("rst_no_relock", lk_rise, -1);
    chk("rst_locked", locked, 0);
    chk("rst_fpc", frame_px_cnt, exp_fpc);
    t0 = cyc;
    run_frame(3, 1, NONE, VT, NONE);
    chk("rst_relock", lk_rise, t0 + 2);
    chk("rst_after_fpc", frame_px_cnt, exp_fpc);

    hs = 1'b1; vs = 1'b1;
    repeat (4) step();
    chk("px_q_drained", px_q.size(), 0);
    chk("cnt_q_drained", cnt_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
